// File: rtl/cpu_pkg.sv
// Shared fetch-path types: FSM state encoding and the response word that
// travels from the program memory back to decode.
package cpu_pkg;

  localparam int ADDR_WIDTH  = 3;
  localparam int INSTR_WIDTH = 8;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_DRAIN,
    FS_LOAD
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  addr;
  } fetch_rsp_t;

endpackage

// File: rtl/rsp_fifo.sv
// Two-entry in-order response queue with synchronous clear; the head entry
// is presented combinationally and held until it is popped.
module rsp_fifo #(
  parameter type entry_t = cpu_pkg::fetch_rsp_t
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  entry_t     push_data,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t slots [2];
  logic   rd_ptr;
  logic   wr_ptr;
  logic   do_push;
  logic   do_pop;

  // A full queue may still take a push when the head leaves in the same cycle.
  assign do_push = push & ~clear & ((count != 2'd2) | pop);
  assign do_pop  = pop & ~clear & (count != 2'd0);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slots[0] <= '0;
      slots[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// Fetch responder: program memory, one-cycle read stage, response queue and
// the RUN/DRAIN/LOAD controller that keeps program loads away from fetches.
module instr_fetch_responder #(
  parameter int ADDR_WIDTH  = cpu_pkg::ADDR_WIDTH,
  parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [INSTR_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0]  rsp_addr,
  input  logic                   rsp_ready,
  input  logic                   flush,
  input  logic                   load_req,
  output logic                   load_ack,
  input  logic                   prog_we,
  input  logic [ADDR_WIDTH-1:0]  prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data
);

  import cpu_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  addr;
  } rsp_entry_t;

  fetch_state_t           state;
  fetch_state_t           state_next;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic                   in_flight;
  rsp_entry_t             read_q;
  rsp_entry_t             head;
  logic [1:0]             fifo_count;
  logic [2:0]             occupancy;
  logic                   req_fire;
  logic                   rsp_fire;

  // A response leaving this cycle frees its slot, so a steady stream keeps full rate.
  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_fire  = rsp_valid & rsp_ready & ~flush;
  assign occupancy = {1'b0, fifo_count} + {2'b0, in_flight} - {2'b0, rsp_fire};
  assign req_ready = (state == FS_RUN) & ~flush & (occupancy < 3'd2);
  assign req_fire  = req_valid & req_ready;
  assign load_ack  = (state == FS_LOAD);
  assign rsp_instr = head.instr;
  assign rsp_addr  = head.addr;

  always_ff @(posedge clock) begin
    if ((state == FS_LOAD) && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_flight <= 1'b0;
      read_q    <= '0;
    end else begin
      in_flight <= req_fire;
      if (req_fire) begin
        read_q <= '{instr: mem[req_addr], addr: req_addr};
      end
    end
  end

  rsp_fifo #(
    .entry_t(rsp_entry_t)
  ) u_rsp_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (in_flight),
    .pop      (rsp_fire),
    .clear    (flush),
    .push_data(read_q),
    .head     (head),
    .count    (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FS_RUN;
    end else begin
      state <= state_next;
    end
  end

  // LOAD is only entered once every accepted fetch has been handed back.
  always_comb begin
    state_next = state;
    case (state)
      FS_RUN: begin
        if (load_req) state_next = FS_DRAIN;
      end
      FS_DRAIN: begin
        if (!load_req) state_next = FS_RUN;
        else if (!in_flight && (fifo_count == 2'd0)) state_next = FS_LOAD;
      end
      FS_LOAD: begin
        if (!load_req) state_next = FS_RUN;
      end
      default: state_next = FS_RUN;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder: program load, streaming,
// backpressure, flush, drain gating and asynchronous reset.
module tb_instr_fetch_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_addr;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_instr;
  logic [2:0] rsp_addr;
  logic       rsp_ready;
  logic       flush;
  logic       load_req;
  logic       load_ack;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [7:0] prog_data;

  int checks = 0;
  int errors = 0;

  instr_fetch_responder dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_instr(rsp_instr),
    .rsp_addr (rsp_addr),
    .rsp_ready(rsp_ready),
    .flush    (flush),
    .load_req (load_req),
    .load_ack (load_ack),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [2:0] a, input logic rr);
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    #1;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; load_req = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    #3;
    check_output("reset_req_ready", req_ready, 1);
    check_output("reset_rsp_valid", rsp_valid, 0);
    check_output("reset_rsp_instr", rsp_instr, 0);
    check_output("reset_rsp_addr", rsp_addr, 0);
    check_output("reset_load_ack", load_ack, 0);
    tick;
    tick;
    reset = 1'b0;

    $display("[TB] program load");
    load_req = 1'b1;
    for (int k = 0; k < 8 && !load_ack; k++) tick;
    check_output("load_ack_rise", load_ack, 1);
    check_output("load_req_ready", req_ready, 0);
    check_output("load_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 8; i++) begin
      prog_we   = 1'b1;
      prog_addr = i[2:0];
      prog_data = 8'hA0 + i[7:0];
      if (i == 7) load_req = 1'b0;
      tick;
    end
    prog_we = 1'b0;
    check_output("load_ack_fall", load_ack, 0);
    check_output("run_req_ready", req_ready, 1);

    $display("[TB] streaming");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(i < 8, i[2:0], 1'b1);
      if (i < 8) check_output("stream_req_ready", req_ready, 1);
      if (i >= 2) begin
        check_output("stream_rsp_valid", rsp_valid, 1);
        check_output("stream_rsp_instr", rsp_instr, 32'hA0 + i - 2);
        check_output("stream_rsp_addr", rsp_addr, i - 2);
      end
      tick;
    end
    check_output("stream_idle", rsp_valid, 0);

    $display("[TB] backpressure");
    apply_stimulus(1'b1, 3'd3, 1'b0);
    check_output("bp_ready_a3", req_ready, 1);
    tick;
    apply_stimulus(1'b1, 3'd4, 1'b0);
    check_output("bp_ready_a4", req_ready, 1);
    tick;
    apply_stimulus(1'b1, 3'd5, 1'b0);
    check_output("bp_ready_stall", req_ready, 0);
    check_output("bp_head_instr", rsp_instr, 32'hA3);
    tick;
    check_output("bp_full_ready", req_ready, 0);
    check_output("bp_hold_instr", rsp_instr, 32'hA3);
    check_output("bp_hold_addr", rsp_addr, 3);
    tick;
    apply_stimulus(1'b1, 3'd5, 1'b1);
    check_output("bp_rel_instr", rsp_instr, 32'hA3);
    check_output("bp_rel_ready", req_ready, 1);
    tick;
    apply_stimulus(1'b0, 3'd0, 1'b1);
    check_output("bp_second_instr", rsp_instr, 32'hA4);
    tick;
    check_output("bp_third_valid", rsp_valid, 1);
    check_output("bp_third_instr", rsp_instr, 32'hA5);
    check_output("bp_third_addr", rsp_addr, 5);
    tick;
    check_output("bp_empty", rsp_valid, 0);

    $display("[TB] flush");
    apply_stimulus(1'b1, 3'd1, 1'b0);
    tick;
    apply_stimulus(1'b1, 3'd2, 1'b0);
    tick;
    check_output("fl_queued_instr", rsp_instr, 32'hA1);
    flush = 1'b1;
    apply_stimulus(1'b1, 3'd7, 1'b1);
    check_output("fl_req_blocked", req_ready, 0);
    tick;
    flush = 1'b0;
    apply_stimulus(1'b0, 3'd0, 1'b1);
    check_output("fl_rsp_cleared", rsp_valid, 0);
    check_output("fl_req_ready", req_ready, 1);
    tick;
    check_output("fl_no_late_push", rsp_valid, 0);
    apply_stimulus(1'b1, 3'd6, 1'b1);
    tick;
    apply_stimulus(1'b0, 3'd0, 1'b1);
    tick;
    check_output("fl_new_valid", rsp_valid, 1);
    check_output("fl_new_instr", rsp_instr, 32'hA6);
    check_output("fl_new_addr", rsp_addr, 6);
    tick;

    $display("[TB] drain and load gating");
    prog_we = 1'b1; prog_addr = 3'd2; prog_data = 8'h55;
    tick;
    prog_we = 1'b0;
    apply_stimulus(1'b1, 3'd2, 1'b0);
    tick;
    apply_stimulus(1'b0, 3'd0, 1'b0);
    tick;
    check_output("run_we_ignored", rsp_instr, 32'hA2);
    load_req = 1'b1;
    tick;
    check_output("drain_no_ack", load_ack, 0);
    check_output("drain_req_ready", req_ready, 0);
    check_output("drain_rsp_valid", rsp_valid, 1);
    tick;
    check_output("drain_still_waiting", load_ack, 0);
    apply_stimulus(1'b0, 3'd0, 1'b1);
    tick;
    check_output("drain_popped_ack", load_ack, 0);
    check_output("drain_popped_valid", rsp_valid, 0);
    tick;
    check_output("drain_to_load", load_ack, 1);
    load_req = 1'b0;
    apply_stimulus(1'b0, 3'd0, 1'b0);
    tick;
    check_output("load_exit_ack", load_ack, 0);
    check_output("load_exit_ready", req_ready, 1);

    $display("[TB] reset mid-stream");
    apply_stimulus(1'b1, 3'd0, 1'b0);
    tick;
    apply_stimulus(1'b1, 3'd1, 1'b0);
    tick;
    apply_stimulus(1'b0, 3'd0, 1'b0);
    tick;
    check_output("rst_full_ready", req_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check_output("rst_async_ready", req_ready, 1);
    check_output("rst_async_valid", rsp_valid, 0);
    check_output("rst_async_instr", rsp_instr, 0);
    check_output("rst_async_addr", rsp_addr, 0);
    check_output("rst_async_ack", load_ack, 0);
    tick;
    reset = 1'b0;
    apply_stimulus(1'b1, 3'd1, 1'b1);
    tick;
    apply_stimulus(1'b0, 3'd0, 1'b1);
    tick;
    check_output("rst_after_valid", rsp_valid, 1);
    check_output("rst_after_instr", rsp_instr, 32'hA1);
    check_output("rst_after_addr", rsp_addr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
